// File: rtl/mxv_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// mxv_seq_ctrl_if : control, operand stream and result stream of mxv_seq_ctrl
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface mxv_seq_ctrl_if #(
  parameter int DW = 32,
  parameter int IW = 3
);
  logic          start;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;

  modport slave (
    input  start, in_valid, in_data, out_ready,
    output busy, done, in_ready, out_valid, out_data, out_idx, out_last
  );

  modport master (
    output start, in_valid, in_data, out_ready,
    input  busy, done, in_ready, out_valid, out_data, out_idx, out_last
  );
endinterface

`default_nettype wire

// File: rtl/mxv_seq_ctrl.sv
// ----------------------------------------------------------------------------
// mxv_seq_ctrl : sequential matrix-vector product, one shared signed MAC
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mxv_seq_ctrl #(
  parameter int ROWS = 3,
  parameter int COLS = 5,
  parameter int DW   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mxv_seq_ctrl_if.slave    bus
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] c_row_last = RW'(ROWS - 1);
  localparam logic [CW-1:0] c_col_last = CW'(COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_V = 2'd1,
    S_LOAD_M = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_done;
  logic   w_done_nxt;
  logic   w_in_ready;
  logic   w_out_valid;
  logic   w_clear;

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          w_row_last;
  logic          w_col_last;
  logic          w_v_hs;
  logic          w_m_hs;
  logic          w_o_hs;

  logic signed [DW-1:0] r_vreg [ROWS];
  logic signed [DW-1:0] r_acc  [COLS];
  logic signed [DW-1:0] w_vsel;
  logic signed [DW-1:0] w_acc_sel;
  logic signed [DW-1:0] w_prod;

  assign w_row_last = (r_row == c_row_last);
  assign w_col_last = (r_col == c_col_last);
  assign w_v_hs     = (r_state == S_LOAD_V) && bus.in_valid;
  assign w_m_hs     = (r_state == S_LOAD_M) && bus.in_valid;
  assign w_o_hs     = (r_state == S_DRAIN)  && bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Handshake strobes only steer the next state; ready/valid decode r_state alone.
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = S_LOAD_V;
          w_clear     = 1'b1;
        end
      end
      S_LOAD_V: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && w_row_last) begin
          w_state_nxt = S_LOAD_M;
        end
      end
      S_LOAD_M: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && w_row_last && w_col_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_out_valid = 1'b1;
        if (bus.out_ready && w_col_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_vsel    = '0;
    w_acc_sel = '0;
    for (int k = 0; k < ROWS; k++) begin
      if (r_row == RW'(k)) w_vsel = r_vreg[k];
    end
    for (int k = 0; k < COLS; k++) begin
      if (r_col == CW'(k)) w_acc_sel = r_acc[k];
    end
  end

  // Low DW bits of the full 2*DW signed product equal the DW-wide product.
  assign w_prod = w_vsel * $signed(bus.in_data);

  always_ff @(posedge clk) begin
    for (int k = 0; k < ROWS; k++) begin
      if (w_v_hs && (r_row == RW'(k))) r_vreg[k] <= $signed(bus.in_data);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_row <= '0;
      r_col <= '0;
      for (int k = 0; k < COLS; k++) r_acc[k] <= '0;
    end else begin
      if (w_clear) begin
        r_row <= '0;
        r_col <= '0;
        for (int k = 0; k < COLS; k++) r_acc[k] <= '0;
      end
      if (w_v_hs) begin
        r_row <= w_row_last ? '0 : r_row + 1'b1;
      end
      if (w_m_hs) begin
        for (int k = 0; k < COLS; k++) begin
          if (r_col == CW'(k)) r_acc[k] <= w_acc_sel + w_prod;
        end
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_o_hs) begin
        r_col <= w_col_last ? '0 : r_col + 1'b1;
      end
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = r_done;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_acc_sel;
  assign bus.out_idx   = r_col;
  assign bus.out_last  = w_out_valid && w_col_last;

endmodule

`default_nettype wire

// File: tb/tb_mxv_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mxv_seq_ctrl : scoreboard bench for mxv_seq_ctrl (3x5 and 1x1 instances)
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mxv_seq_ctrl;

  typedef struct {
    int data;
    int idx;
    int last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_mis = 0;
  int   n_done = 0;
  int   n_done1 = 0;
  int   exp_done = 0;
  bit   rnd_ready = 1'b0;
  exp_t sb[$];
  exp_t sb1[$];

  int V0[3]  = '{1, 2, 3};
  int M0[15] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
  int E0[5]  = '{46, 52, 58, 64, 70};
  int V1[3]  = '{-1, 0, 2};
  int M1[15] = '{7, 7, 7, 7, 7, 5, 5, 5, 5, 5, -3, -3, -3, -3, -3};
  int E1[5]  = '{-13, -13, -13, -13, -13};
  int V2[3]  = '{1073741824, 2, 0};
  int M2[15] = '{4, 4, 4, 4, 4, 1, 1, 1, 1, 1, 9, 9, 9, 9, 9};
  int E2[5]  = '{2, 2, 2, 2, 2};

  mxv_seq_ctrl_if #(.DW(32), .IW(3)) bus ();
  mxv_seq_ctrl_if #(.DW(32), .IW(1)) bus1 ();

  mxv_seq_ctrl #(.ROWS(3), .COLS(5), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  mxv_seq_ctrl #(.ROWS(1), .COLS(1), .DW(32)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic note_fail(input string nm);
    n_vec++;
    n_mis++;
    $display("FAIL %s: timed out or unexpected event", nm);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor for the 3x5 instance: scoreboard pop and stall-stability check.
  logic [31:0] hold_data;
  logic [2:0]  hold_idx;
  bit          held = 1'b0;
  always @(negedge clk) begin : mon0
    exp_t ex;
    if (rst_n && bus.out_valid) begin
      if (held) begin
        check("hold_data", bus.out_data, hold_data);
        check("hold_idx", {29'd0, bus.out_idx}, {29'd0, hold_idx});
      end
      held      = !bus.out_ready;
      hold_data = bus.out_data;
      hold_idx  = bus.out_idx;
      if (bus.out_ready) begin
        if (sb.size() == 0) begin
          note_fail("unexpected_result");
        end else begin
          ex = sb.pop_front();
          check("out_data", bus.out_data, ex.data);
          check("out_idx", {29'd0, bus.out_idx}, ex.idx);
          check("out_last", {31'd0, bus.out_last}, ex.last);
        end
      end
    end else begin
      held = 1'b0;
    end
    if (bus.done) n_done++;
  end

  always @(negedge clk) begin : mon1
    exp_t ex;
    if (rst_n && bus1.out_valid && bus1.out_ready) begin
      if (sb1.size() == 0) begin
        note_fail("unexpected_result_1x1");
      end else begin
        ex = sb1.pop_front();
        check("out_data_1x1", bus1.out_data, ex.data);
        check("out_idx_1x1", {31'd0, bus1.out_idx}, ex.idx);
        check("out_last_1x1", {31'd0, bus1.out_last}, ex.last);
      end
    end
    if (bus1.done) n_done1++;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_elem(input int x, input bit stall, input bit spulse);
    bit acc;
    int g;
    acc = 1'b0;
    g   = 0;
    while (!acc && g < 100) begin
      bus.in_data  = x;
      bus.in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.start    = spulse;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    if (!acc) note_fail("input_accept");
  endtask

  // Called at posedge+1; returns at posedge+1 of the done cycle.
  task automatic run_job(input int v[3], input int m[15], input int e[5],
                         input bit stall, input int pulse_k, input bit drain_pulse);
    exp_t x;
    int   cs;
    int   g;
    bit   seen;
    bit   pulsed;
    for (int j = 0; j < 5; j++) begin
      x.data = e[j];
      x.idx  = j;
      x.last = (j == 4) ? 1 : 0;
      sb.push_back(x);
    end
    bus.start = 1'b1;
    cs = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) send_elem(v[i], stall, 1'b0);
    for (int i = 0; i < 15; i++) send_elem(m[i], stall, i == pulse_k);
    seen   = 1'b0;
    pulsed = 1'b0;
    g      = 0;
    while (!seen && g < 400) begin
      @(posedge clk);
      #1;
      g++;
      bus.start = 1'b0;
      if (bus.done) begin
        seen = 1'b1;
      end else if (drain_pulse && !pulsed && bus.out_valid) begin
        bus.start = 1'b1;
        pulsed    = 1'b1;
      end
    end
    bus.start = 1'b0;
    exp_done++;
    if (!seen) begin
      note_fail("done_wait");
    end else begin
      if (!stall) check("done_latency", cyc - cs, 24);
      check("sb_drained", sb.size(), 0);
    end
  endtask

  initial begin : main
    int d0;
    int cs;
    int g;
    bit seen;
    exp_t x;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    bus1.start    = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;
    bus1.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_out_last", {31'd0, bus.out_last}, 0);
    check("rst_out_idx", {29'd0, bus.out_idx}, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy_1x1", {31'd0, bus1.busy}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    run_job(V0, M0, E0, 1'b0, -1, 1'b0);
    idle(3);
    rnd_ready = 1'b1;
    run_job(V0, M0, E0, 1'b1, -1, 1'b0);
    rnd_ready = 1'b0;
    idle(3);
    run_job(V1, M1, E1, 1'b0, -1, 1'b0);
    idle(2);
    run_job(V2, M2, E2, 1'b0, -1, 1'b0);
    idle(2);
    run_job(V0, M0, E0, 1'b0, 8, 1'b1);
    idle(2);
    run_job(V0, M0, E0, 1'b0, -1, 1'b0);
    run_job(V1, M1, E1, 1'b0, -1, 1'b0);
    idle(4);

    // Abort after 7 matrix elements.
    d0 = n_done;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) send_elem(V0[i], 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) send_elem(M0[i], 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, bus.busy}, 0);
    check("abort_in_ready", {31'd0, bus.in_ready}, 0);
    check("abort_out_valid", {31'd0, bus.out_valid}, 0);
    idle(10);
    check("abort_no_done", n_done, d0);
    run_job(V0, M0, E0, 1'b0, -1, 1'b0);
    idle(3);

    // 1x1 instance: -4 * 9.
    x.data = -36;
    x.idx  = 0;
    x.last = 1;
    sb1.push_back(x);
    bus1.start = 1'b1;
    cs = cyc;
    @(posedge clk);
    #1;
    bus1.start    = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.in_data  = -32'sd4;
    @(posedge clk);
    #1;
    bus1.in_data  = 32'sd9;
    @(posedge clk);
    #1;
    bus1.in_valid = 1'b0;
    seen = 1'b0;
    g    = 0;
    while (!seen && g < 50) begin
      if (bus1.done) begin
        seen = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        g++;
      end
    end
    if (!seen) note_fail("done_wait_1x1");
    else check("done_latency_1x1", cyc - cs, 4);
    idle(3);
    check("sb1_drained", sb1.size(), 0);
    check("done_count_1x1", n_done1, 1);
    check("done_count", n_done, exp_done);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mxv_seq_ctrl.md
# mxv_seq_ctrl

Sequential controller for the matrix-vector product. It computes result[j] = sum over i of vector[i]*matrix[i][j], where the matrix is ROWS x COLS and the vector has ROWS elements. One shared signed multiply-accumulate unit serves the whole product. Operands arrive over a single valid/ready input stream and results leave over a valid/ready output stream, so the block can replace the combinational mxv datapath where area matters.

## Interface
- ROWS, default 3: matrix rows, equal to the vector length.
- COLS, default 5: matrix columns, equal to the result length.
- DW, default 32: signed data width of operands and results.
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begins a job; sampled only in IDLE.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse after the last result handshake.
- in_valid  in  1  input element valid.
- in_ready  out  1  block can accept an input element.
- in_data  in  DW  signed operand.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DW  signed result[out_idx].
- out_idx  out  $clog2(COLS)  index j of the current result.
- out_last  out  1  high with the result for j = COLS-1.

## Operation
- States: IDLE, LOAD_V, LOAD_M, DRAIN.
- IDLE:
  - start=1 moves to LOAD_V.
  - All COLS accumulators and the row/column counters clear on the same edge.
  - start in any other state has no effect.
- LOAD_V:
  - in_ready=1.
  - Each handshake (in_valid & in_ready) stores in_data into vreg[i] and increments i.
  - After ROWS handshakes, moves to LOAD_M with i=0, j=0.
- LOAD_M:
  - in_ready=1. Matrix elements arrive row-major: m[0][0..COLS-1], then m[1][...], and so on.
  - Each handshake performs acc[j] <= acc[j] + vreg[i]*in_data.
  - j wraps at COLS-1 and i then increments.
  - After ROWS*COLS handshakes, moves to DRAIN with j=0.
- DRAIN:
  - out_valid=1, out_data=acc[j], out_idx=j, out_last=(j==COLS-1).
  - Each handshake (out_valid & out_ready) increments j.
  - The handshake with out_last moves to IDLE and sets done=1 for the next cycle.
- Arithmetic:
  - The product is a full 2*DW signed value.
  - The accumulator keeps the low DW bits, with two's-complement wraparound.
  - No saturation and no overflow flag.
- Cleared job state: vreg values are don't-care until rewritten; accumulators are re-cleared by the next start.
- in_ready=0 in IDLE and DRAIN. Input data offered there is ignored and not counted.
- out_valid=0 outside DRAIN. out_data, out_idx and out_last are don't-care when out_valid=0.

## Timing
- Reset values: state IDLE, busy=0, done=0, in_ready=0, out_valid=0, out_idx=0, out_last=0, out_data=0, all counters 0, all accumulators 0.
- rst_n=0 in any state, including mid-load or mid-drain:
  - Aborts the job on that edge.
  - No done pulse and no further outputs.
- in_ready, out_valid, out_last and busy are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- Cycle timing from start:
  - start is sampled at edge 0.
  - in_ready=1 from cycle 1.
  - With in_valid held high, the last matrix element is accepted at edge ROWS+ROWS*COLS.
  - out_valid=1 in the following cycle.
- Minimum job length, with no stalls and out_ready held high:
  - ROWS + ROWS*COLS + COLS + 1 cycles from start to done.
  - This is 24 cycles at the defaults.
- Back-to-back jobs:
  - start may be asserted in the cycle done=1, because state is already IDLE.
  - Minimum gap between jobs is 0 cycles.
- Input stalls: in_valid=0 holds all counters and accumulators.
- Output stalls: out_ready=0 holds out_data, out_idx and out_last stable while out_valid=1.

## Test plan
- Default parameters, no stalls. Vector {1,2,3}; matrix rows {1,2,3,4,5}, {6,7,8,9,10}, {11,12,13,14,15}. Required: results 46, 52, 58, 64, 70 at idx 0..4; out_last on idx 4; done 24 cycles after start.
- Same operands with in_valid randomly deasserted (about 50%) and out_ready randomly deasserted. Required: identical results, and out_data/out_idx stable during every out_ready=0 cycle.
- Signed values and wraparound:
  - Vector {-1,0,2}; matrix row0 all 7, row1 all 5, row2 all -3. Required: all results -13.
  - Then vector {2^30,2,0}; matrix row0 all 4, row1 all 1. Required: all results 2 (2^32 wraps to 0).
- start pulsed during LOAD_M and during DRAIN. Required: ignored, and the job completes with correct results. Then two back-to-back jobs with start asserted in the done cycle. Required: the second job's results are independent of the first, confirming the accumulators were cleared.
- rst_n=0 for one cycle after 7 matrix elements have been accepted. Required: next cycle busy=0, in_ready=0, out_valid=0, no done pulse. A following full job produces 46, 52, 58, 64, 70.
- ROWS=1, COLS=1. Vector {-4}; matrix {9}. Required: a single result -36 with out_last=1 and out_idx=0, and done 4 cycles after start.
